// File: rtl/jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_tap_ctrl
//  Description : IEEE 1149.1 TAP controller driving a boundary-scan cell
//                chain. TCK/TMS/TDI are oversampled on ICLK. TCK edges are
//                turned into single-cycle rise/fall events, and those events
//                step the 16-state TAP FSM. The block holds the IR, IDCODE
//                and BYPASS registers, muxes TDO, and drives the cell
//                control strobes.
//  Ports       : ICLK, RST         system clock / async active-high reset
//                TCK, TMS, TDI     JTAG pins (asynchronous to ICLK)
//                TDO, TDO_EN       JTAG data out and its output enable
//                bsr_si, bsr_so    serial in/out of the boundary-scan chain
//                shift_dr          cell shift select (level)
//                clk_dr, update_dr cell capture/shift and update strobes
//                mode              cell output select (1 = EXTEST)
//                ir_out            current instruction
//                tap_state         FSM state code
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_ctrl #(
    parameter int          IR_WIDTH    = 4,
    parameter logic [31:0] IDCODE_VAL  = 32'h0A5C_3001,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                ICLK,
    input  logic                RST,
    input  logic                TCK,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_EN,
    output logic                bsr_si,
    input  logic                bsr_so,
    output logic                shift_dr,
    output logic                clk_dr,
    output logic                update_dr,
    output logic                mode,
    output logic [IR_WIDTH-1:0] ir_out,
    output logic [3:0]          tap_state
);

    typedef enum logic [3:0] {
        TLR   = 4'hF, RTI   = 4'hC, SELDR = 4'h7, CAPDR = 4'h6,
        SHDR  = 4'h2, EX1DR = 4'h1, PSDR  = 4'h3, EX2DR = 4'h0,
        UPDDR = 4'h5, SELIR = 4'h4, CAPIR = 4'hE, SHIR  = 4'hA,
        EX1IR = 4'h9, PSIR  = 4'hB, EX2IR = 4'h8, UPDIR = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IR_EXTEST = '0;
    localparam logic [IR_WIDTH-1:0] IR_SAMPLE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(2);

    // Pin synchronizers. TMS/TDI share the TCK pipeline depth, so the
    // synced TMS/TDI seen on a tck_rise cycle is the value at the pin edge.
    logic [SYNC_STAGES-1:0] tck_sync_q, tms_sync_q, tdi_sync_q;
    logic                   tck_edge_q;
    logic                   tck_s, tms_s, tdi_s, tck_rise, tck_fall;

    assign tck_s    = tck_sync_q[SYNC_STAGES-1];
    assign tms_s    = tms_sync_q[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync_q[SYNC_STAGES-1];
    assign tck_rise =  tck_s & ~tck_edge_q;
    assign tck_fall = ~tck_s &  tck_edge_q;

    always_ff @(posedge ICLK or posedge RST) begin
        if (RST) begin
            tck_sync_q <= '0;
            tms_sync_q <= '0;
            tdi_sync_q <= '0;
            tck_edge_q <= 1'b0;
        end else begin
            tck_sync_q <= {tck_sync_q[SYNC_STAGES-2:0], TCK};
            tms_sync_q <= {tms_sync_q[SYNC_STAGES-2:0], TMS};
            tdi_sync_q <= {tdi_sync_q[SYNC_STAGES-2:0], TDI};
            tck_edge_q <= tck_s;
        end
    end

    // TAP state machine
    tap_state_e state_q, state_d;

    always_ff @(posedge ICLK or posedge RST) begin
        if (RST) state_q <= TLR;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            case (state_q)
                TLR:   if (!tms_s) state_d = RTI;
                RTI:   if (tms_s)  state_d = SELDR;
                SELDR: state_d = tms_s ? SELIR : CAPDR;
                SELIR: state_d = tms_s ? TLR   : CAPIR;
                CAPDR: state_d = tms_s ? EX1DR : SHDR;
                SHDR:  if (tms_s)  state_d = EX1DR;
                EX1DR: state_d = tms_s ? UPDDR : PSDR;
                PSDR:  if (tms_s)  state_d = EX2DR;
                EX2DR: state_d = tms_s ? UPDDR : SHDR;
                UPDDR: state_d = tms_s ? SELDR : RTI;
                CAPIR: state_d = tms_s ? EX1IR : SHIR;
                SHIR:  if (tms_s)  state_d = EX1IR;
                EX1IR: state_d = tms_s ? UPDIR : PSIR;
                PSIR:  if (tms_s)  state_d = EX2IR;
                EX2IR: state_d = tms_s ? UPDIR : SHIR;
                UPDIR: state_d = tms_s ? SELDR : RTI;
                default: state_d = TLR;
            endcase
        end
    end

    // Registers and TDO path
    logic [IR_WIDTH-1:0] ir_sr_q, ir_q;
    logic [31:0]         idcode_q;
    logic                byp_q, mode_q, tdo_q, tdo_en_q;
    logic                bsr_sel, dr_lsb;

    // Undefined instruction codes fall into the default arm (BYPASS).
    always_comb begin
        bsr_sel = (ir_q == IR_EXTEST) || (ir_q == IR_SAMPLE);
        if (bsr_sel)                dr_lsb = bsr_so;
        else if (ir_q == IR_IDCODE) dr_lsb = idcode_q[0];
        else                        dr_lsb = byp_q;
    end

    always_ff @(posedge ICLK or posedge RST) begin
        if (RST) begin
            ir_sr_q  <= '0;
            ir_q     <= IR_IDCODE;
            mode_q   <= 1'b0;
            idcode_q <= '0;
            byp_q    <= 1'b0;
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            if (tck_rise) begin
                case (state_q)
                    CAPIR: ir_sr_q <= IR_WIDTH'(1);
                    SHIR:  ir_sr_q <= {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
                    CAPDR: begin
                        idcode_q <= IDCODE_VAL;
                        byp_q    <= 1'b0;
                    end
                    SHDR: begin
                        idcode_q <= {tdi_s, idcode_q[31:1]};
                        byp_q    <= tdi_s;
                    end
                    default: ;
                endcase
            end

            if (tck_fall) begin
                if (state_q == SHIR) begin
                    tdo_q    <= ir_sr_q[0];
                    tdo_en_q <= 1'b1;
                end else if (state_q == SHDR) begin
                    tdo_q    <= dr_lsb;
                    tdo_en_q <= 1'b1;
                end else begin
                    tdo_en_q <= 1'b0;
                end
            end

            // Test-Logic-Reset keeps the instruction pinned to IDCODE.
            if (state_q == TLR) begin
                ir_q   <= IR_IDCODE;
                mode_q <= 1'b0;
            end else if (tck_fall && state_q == UPDIR) begin
                ir_q   <= ir_sr_q;
                mode_q <= (ir_sr_q == IR_EXTEST);
            end
        end
    end

    // Cell strobes derive from the single-cycle edge events, so they are
    // one ICLK wide and vanish when the sync flops are reset.
    assign clk_dr    = tck_rise & bsr_sel & ((state_q == CAPDR) || (state_q == SHDR));
    assign update_dr = tck_fall & bsr_sel & (state_q == UPDDR);
    assign shift_dr  = bsr_sel & (state_q == SHDR);

    assign bsr_si    = tdi_s;
    assign TDO       = tdo_q;
    assign TDO_EN    = tdo_en_q;
    assign mode      = mode_q;
    assign ir_out    = ir_q;
    assign tap_state = state_q;

endmodule
`default_nettype wire
